// File: rtl/imem_arbiter_if.sv
// Bus bundle for the instruction-memory arbiter: fetch port, debug/loader port,
// halt handshake and the shared memory port.
interface imem_arbiter_if #(
    parameter int IMEM_W = 32
);
    logic              fetch_req_i;
    logic [IMEM_W-1:0] fetch_addr_i;
    logic              fetch_gnt_o;
    logic              fetch_rvalid_o;
    logic [31:0]       fetch_rdata_o;

    logic              dbg_req_i;
    logic              dbg_we_i;
    logic [IMEM_W-1:0] dbg_addr_i;
    logic [31:0]       dbg_wdata_i;
    logic              dbg_gnt_o;
    logic              dbg_rvalid_o;
    logic [31:0]       dbg_rdata_o;

    logic              dbg_halt_i;
    logic              halted_o;

    logic [IMEM_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  fetch_req_i, fetch_addr_i,
        output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
        input  dbg_halt_i,
        output halted_o,
        output mem_addr_o, mem_we_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output fetch_req_i, fetch_addr_i,
        input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
        output dbg_halt_i,
        input  halted_o,
        input  mem_addr_o, mem_we_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one combinational-read instruction memory between
// fetch and the debug/loader port, with a halt mode that fences fetch off.
//
// state | meaning
// ARB   | fetch and debug arbitrated round-robin
// HALT  | fetch fenced, debug granted every cycle it requests
module imem_arbiter #(
    parameter int IMEM_W = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    imem_arbiter_if.slave bus
);
    typedef enum logic {ARB, HALT} state_t;

    state_t            state, state_nxt;
    logic              last_dbg, last_dbg_nxt;
    logic              fetch_gnt, dbg_gnt;
    logic [IMEM_W-1:0] addr_mux;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ARB;
            last_dbg <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_dbg <= last_dbg_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        last_dbg_nxt = last_dbg;
        fetch_gnt    = 1'b0;
        dbg_gnt      = 1'b0;
        case (state)
            ARB: begin
                if (bus.fetch_req_i && bus.dbg_req_i) begin
                    fetch_gnt = last_dbg;
                    dbg_gnt   = ~last_dbg;
                end else begin
                    fetch_gnt = bus.fetch_req_i;
                    dbg_gnt   = bus.dbg_req_i;
                end
                if (fetch_gnt) last_dbg_nxt = 1'b0;
                if (dbg_gnt)   last_dbg_nxt = 1'b1;
                if (bus.dbg_halt_i) state_nxt = HALT;
            end
            HALT: begin
                dbg_gnt      = bus.dbg_req_i;
                // Pointer parked on debug so fetch wins the first tie after release.
                last_dbg_nxt = 1'b1;
                if (!bus.dbg_halt_i) state_nxt = ARB;
            end
            default: state_nxt = ARB;
        endcase
    end

    assign bus.fetch_gnt_o = fetch_gnt;
    assign bus.dbg_gnt_o   = dbg_gnt;
    assign bus.halted_o    = (state == HALT);

    assign addr_mux        = dbg_gnt ? bus.dbg_addr_i : bus.fetch_addr_i;
    assign bus.mem_addr_o  = addr_mux;
    assign bus.mem_we_o    = dbg_gnt & bus.dbg_we_i;
    assign bus.mem_wdata_o = dbg_gnt ? bus.dbg_wdata_i : 32'h0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.fetch_rvalid_o <= 1'b0;
            bus.fetch_rdata_o  <= 32'h0;
            bus.dbg_rvalid_o   <= 1'b0;
            bus.dbg_rdata_o    <= 32'h0;
        end else begin
            bus.fetch_rvalid_o <= fetch_gnt;
            bus.dbg_rvalid_o   <= dbg_gnt;
            if (fetch_gnt) bus.fetch_rdata_o <= bus.mem_rdata_i;
            if (dbg_gnt)   bus.dbg_rdata_o   <= bus.dbg_we_i ? 32'h0 : bus.mem_rdata_i;
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized scoreboard bench for imem_arbiter: a per-cycle reference model predicts
// grants and responses; a negedge monitor pops and checks responses as they appear.
module tb_imem_arbiter;
    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ncyc = 0;

    exp_t fq[$];
    exp_t dq[$];

    logic [31:0] tb_mem  [64];
    logic [31:0] ref_mem [64];
    logic        mhalt = 1'b0;
    logic        mlast_dbg = 1'b1;

    imem_arbiter_if #(.IMEM_W(32)) bus ();

    imem_arbiter #(.IMEM_W(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata_i = tb_mem[bus.mem_addr_o[7:2]];
    always @(posedge clk) if (bus.mem_we_o) tb_mem[bus.mem_addr_o[7:2]] <= bus.mem_wdata_o;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.fetch_req_i  = 1'b0;
        bus.fetch_addr_i = 32'h0;
        bus.dbg_req_i    = 1'b0;
        bus.dbg_we_i     = 1'b0;
        bus.dbg_addr_i   = 32'h0;
        bus.dbg_wdata_i  = 32'h0;
        bus.dbg_halt_i   = 1'b0;
    endtask

    // One cycle: drive, check grants/mux against the model, queue expected responses.
    task automatic step(input logic fr, input logic [31:0] fa, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dd, input logic h);
        logic gf, gd;
        exp_t e;
        @(posedge clk);
        #2;
        bus.fetch_req_i  = fr;
        bus.fetch_addr_i = fa;
        bus.dbg_req_i    = dr;
        bus.dbg_we_i     = dw;
        bus.dbg_addr_i   = da;
        bus.dbg_wdata_i  = dd;
        bus.dbg_halt_i   = h;
        #1;
        if (mhalt) begin
            gf = 1'b0;
            gd = dr;
        end else if (fr && dr) begin
            gf = mlast_dbg;
            gd = !mlast_dbg;
        end else begin
            gf = fr;
            gd = dr;
        end
        chk("fetch_gnt", {31'h0, bus.fetch_gnt_o}, {31'h0, gf});
        chk("dbg_gnt", {31'h0, bus.dbg_gnt_o}, {31'h0, gd});
        chk("halted", {31'h0, bus.halted_o}, {31'h0, mhalt});
        chk("mem_addr", bus.mem_addr_o, gd ? da : fa);
        chk("mem_we", {31'h0, bus.mem_we_o}, {31'h0, gd && dw});
        if (gd && dw) chk("mem_wdata", bus.mem_wdata_o, dd);
        if (!gf && !gd) chk("mem_wdata_idle", bus.mem_wdata_o, 32'h0);
        if (gf) begin
            e.data = ref_mem[fa[7:2]];
            e.due  = ncyc + 2;
            fq.push_back(e);
            mlast_dbg = 1'b0;
        end
        if (gd) begin
            e.data = dw ? 32'h0 : ref_mem[da[7:2]];
            e.due  = ncyc + 2;
            dq.push_back(e);
            if (dw) ref_mem[da[7:2]] = dd;
            mlast_dbg = 1'b1;
        end
        if (mhalt) mlast_dbg = 1'b1;
        mhalt = h;
    endtask

    // Async reset pulse landing between the last step's grant and the next edge.
    task automatic reset_pulse();
        #1;
        rst_n = 1'b0;
        idle_inputs();
        fq.delete();
        dq.delete();
        mhalt     = 1'b0;
        mlast_dbg = 1'b1;
        #1;
        chk("rst_fetch_rvalid", {31'h0, bus.fetch_rvalid_o}, 32'h0);
        chk("rst_halted", {31'h0, bus.halted_o}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_dbg_rvalid", {31'h0, bus.dbg_rvalid_o}, 32'h0);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (bus.fetch_rvalid_o) begin
                if (fq.size() == 0) chk("fetch_rvalid_unexpected", 32'h1, 32'h0);
                else begin
                    e = fq.pop_front();
                    chk("fetch_rdata", bus.fetch_rdata_o, e.data);
                    chk("fetch_latency", ncyc, e.due);
                end
            end else if (fq.size() != 0 && fq[0].due <= ncyc) begin
                e = fq.pop_front();
                chk("fetch_rvalid_missing", 32'h0, 32'h1);
            end
            if (bus.dbg_rvalid_o) begin
                if (dq.size() == 0) chk("dbg_rvalid_unexpected", 32'h1, 32'h0);
                else begin
                    e = dq.pop_front();
                    chk("dbg_rdata", bus.dbg_rdata_o, e.data);
                    chk("dbg_latency", ncyc, e.due);
                end
            end else if (dq.size() != 0 && dq[0].due <= ncyc) begin
                e = dq.pop_front();
                chk("dbg_rvalid_missing", 32'h0, 32'h1);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        logic        h;
        logic        fr, dr, dw;
        logic [31:0] fa, da, dd;
        for (int i = 0; i < 64; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        tb_mem[2]  = 32'h00500093;
        ref_mem[2] = 32'h00500093;
        idle_inputs();
        #3;
        chk("reset_fetch_rvalid", {31'h0, bus.fetch_rvalid_o}, 32'h0);
        chk("reset_dbg_rvalid", {31'h0, bus.dbg_rvalid_o}, 32'h0);
        chk("reset_fetch_rdata", bus.fetch_rdata_o, 32'h0);
        chk("reset_dbg_rdata", bus.dbg_rdata_o, 32'h0);
        chk("reset_halted", {31'h0, bus.halted_o}, 32'h0);
        #10;
        rst_n = 1'b1;

        step(1, 32'h8, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 32'(4 * i), 1, 0, 32'(32 + 4 * i), 0, 0);
        step(0, 0, 1, 1, 32'h10, 32'hDEADBEEF, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h10, 0, 0, 0, 0, 0);
        step(1, 32'h13, 0, 0, 0, 0, 0);
        step(1, 32'h4, 1, 0, 32'h8, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 32'h4, 1, 0, 32'(4 * i), 0, 1);
        step(1, 32'h4, 1, 0, 32'h8, 0, 0);
        step(1, 32'hC, 1, 0, 32'h18, 0, 0);
        step(1, 32'hC, 1, 0, 32'h18, 0, 0);
        step(1, 32'h8, 0, 0, 0, 0, 0);
        reset_pulse();
        step(1, 32'h8, 1, 0, 32'h10, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 32'h8, 1, 0, 32'h10, 0, 1);
        reset_pulse();
        step(1, 32'h8, 1, 0, 32'h10, 0, 0);

        h = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) h = !h;
            fr = ($urandom_range(0, 9) < 7);
            dr = ($urandom_range(0, 1) == 1);
            dw = ($urandom_range(0, 9) < 3);
            fa = 32'($urandom_range(0, 255));
            da = 32'($urandom_range(0, 255));
            dd = $urandom;
            step(fr, fa, dr, dw, da, dd, h);
            if (i == 200) reset_pulse();
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("fetch_queue_drained", 32'(fq.size()), 32'h0);
        chk("dbg_queue_drained", 32'(dq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
